// File: rtl/sprite_renderer_pkg.sv
// Shared types and helpers for the sprite renderer.
package sprite_pkg;

   typedef enum logic [3:0] {
      WALL0  = 4'd0,
      WALL1  = 4'd1,
      WALL2  = 4'd2,
      WALL3  = 4'd3,
      WALL4  = 4'd4,
      WALL5  = 4'd5,
      WALL6  = 4'd6,
      WALL7  = 4'd7,
      PELLET = 4'd9,
      POWER  = 4'd10,
      PACMAN = 4'd11
   } sprite_code_t;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      UP    = 2'd1,
      LEFT  = 2'd2,
      DOWN  = 2'd3
   } dir_t;

   // All-ones value of a colour channel of width w.
   function automatic int color_max(input int w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Pixel request / RGB response bundle between tile fetch, renderer and VGA mux.
interface sprite_if #(
   parameter int TILE_W  = 8,
   parameter int COLOR_W = 4
);
   localparam int CW = $clog2(TILE_W);

   logic               in_valid;
   logic [CW-1:0]      sx;
   logic [CW-1:0]      sy;
   logic [3:0]         sprite_code;
   logic [1:0]         pac_dir;
   logic               out_valid;
   logic [COLOR_W-1:0] R;
   logic [COLOR_W-1:0] G;
   logic [COLOR_W-1:0] B;
   logic               mouth_open;

   modport master (
      output in_valid, sx, sy, sprite_code, pac_dir,
      input  out_valid, R, G, B, mouth_open
   );

   modport slave (
      input  in_valid, sx, sy, sprite_code, pac_dir,
      output out_valid, R, G, B, mouth_open
   );
endinterface

// File: rtl/sprite_renderer_anim.sv
// Frame-synchronised animation phases: Pac-Man mouth and power-pellet blink.
module sprite_anim_ctrl #(
   parameter int ANIM_DIV  = 8,
   parameter int BLINK_DIV = 16,
   parameter int BLINK_EN  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_start,
   output logic mouth_open,
   output logic pellet_on
);
   localparam int MW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

   logic [MW-1:0] mouth_cnt;

   // Mouth phase: toggle once every ANIM_DIV frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mouth_cnt  <= '0;
         mouth_open <= 1'b0;
      end else if (frame_start) begin
         if (mouth_cnt == MW'(ANIM_DIV - 1)) begin
            mouth_cnt  <= '0;
            mouth_open <= ~mouth_open;
         end else begin
            mouth_cnt <= mouth_cnt + 1'b1;
         end
      end
   end

   generate
      if (BLINK_EN != 0) begin : g_blink
         localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
         logic [BW-1:0] blink_cnt;

         // Pellet phase: toggle once every BLINK_DIV frames, visible out of reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               blink_cnt <= '0;
               pellet_on <= 1'b1;
            end else if (frame_start) begin
               if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                  blink_cnt <= '0;
                  pellet_on <= ~pellet_on;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
         end
      end else begin : g_noblink
         assign pellet_on = 1'b1;
      end
   endgenerate

endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pipelined tile sprite renderer with animated Pac-Man and pellets.
module sprite_renderer
   import sprite_pkg::*;
#(
   parameter int TILE_W    = 8,
   parameter int COLOR_W   = 4,
   parameter int ANIM_DIV  = 8,
   parameter int BLINK_DIV = 16,
   parameter int BLINK_EN  = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     frame_start,
   sprite_if.slave  bus
);
   localparam int CW  = $clog2(TILE_W);
   localparam int DW  = CW + 2;
   localparam int SQW = 2 * DW;

   localparam logic [COLOR_W-1:0] FULL    = COLOR_W'(color_max(COLOR_W));
   localparam logic [CW-1:0]      C_LO    = CW'(TILE_W / 2 - 1);
   localparam logic [CW-1:0]      C_MID   = CW'(TILE_W / 2);
   localparam logic [CW-1:0]      C_HI    = CW'(TILE_W / 2 + 1);
   localparam logic [SQW-1:0]     RAD_SQ  = SQW'(TILE_W * TILE_W);
   localparam logic signed [DW-1:0] ZERO  = '0;

   logic mouth_open, pellet_on;

   sprite_anim_ctrl #(
      .ANIM_DIV  (ANIM_DIV),
      .BLINK_DIV (BLINK_DIV),
      .BLINK_EN  (BLINK_EN)
   ) u_anim (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .mouth_open  (mouth_open),
      .pellet_on   (pellet_on)
   );

   assign bus.mouth_open = mouth_open;

   // Centre-relative coordinates in half-pixel units, so the tile centre is 0.
   logic signed [DW-1:0] dx_in, dy_in;
   assign dx_in = $signed({1'b0, bus.sx, 1'b0}) - $signed(DW'(TILE_W - 1));
   assign dy_in = $signed({1'b0, bus.sy, 1'b0}) - $signed(DW'(TILE_W - 1));

   logic                 v1, mouth1, pellet1;
   logic [CW-1:0]        sx1, sy1;
   logic [3:0]           code1;
   dir_t                 dir1;
   logic signed [DW-1:0] dx1, dy1;

   // Stage 1: capture request and the animation phase seen on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         sx1     <= '0;
         sy1     <= '0;
         code1   <= '0;
         dir1    <= RIGHT;
         dx1     <= '0;
         dy1     <= '0;
         mouth1  <= 1'b0;
         pellet1 <= 1'b1;
      end else begin
         v1      <= bus.in_valid;
         sx1     <= bus.sx;
         sy1     <= bus.sy;
         code1   <= bus.sprite_code;
         dir1    <= dir_t'(bus.pac_dir);
         dx1     <= dx_in;
         dy1     <= dy_in;
         mouth1  <= mouth_open;
         pellet1 <= pellet_on;
      end
   end

   logic [DW-1:0]  adx, ady;
   logic [SQW-1:0] dist_sq;
   logic           in_disc, in_mouth;
   logic           pel_hit, pow_hit;

   assign adx     = dx1[DW-1] ? -dx1 : dx1;
   assign ady     = dy1[DW-1] ? -dy1 : dy1;
   assign dist_sq = SQW'(adx) * SQW'(adx) + SQW'(ady) * SQW'(ady);
   assign in_disc = (dist_sq <= RAD_SQ);
   assign pel_hit = (sx1 == C_LO || sx1 == C_MID) && (sy1 == C_LO || sy1 == C_MID);
   assign pow_hit = (sx1 >= C_LO) && (sx1 <= C_HI) && (sy1 >= C_LO) && (sy1 <= C_HI);

   // Mouth wedge: 90-degree sector opening in the facing direction.
   always_comb begin
      in_mouth = 1'b0;
      if (mouth1) begin
         case (dir1)
            RIGHT:   in_mouth = (dx1 > ZERO) && (ady < adx);
            LEFT:    in_mouth = (dx1 < ZERO) && (ady < adx);
            UP:      in_mouth = (dy1 < ZERO) && (adx < ady);
            DOWN:    in_mouth = (dy1 > ZERO) && (adx < ady);
            default: in_mouth = 1'b0;
         endcase
      end
   end

   logic [COLOR_W-1:0] r_n, g_n, b_n;

   // Colour selection; invalid slots render black.
   always_comb begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
      if (v1) begin
         if (!code1[3]) begin
            r_n = FULL;
         end else begin
            case (code1)
               PELLET:  if (pel_hit) g_n = FULL;
               POWER:   if (pow_hit && pellet1) b_n = FULL;
               PACMAN:  if (in_disc && !in_mouth) begin
                           r_n = FULL;
                           g_n = FULL;
                        end
               default: ;
            endcase
         end
      end
   end

   // Stage 2: register the pixel colour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.R         <= '0;
         bus.G         <= '0;
         bus.B         <= '0;
      end else begin
         bus.out_valid <= v1;
         bus.R         <= r_n;
         bus.G         <= g_n;
         bus.B         <= b_n;
      end
   end

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer (TILE_W=8, COLOR_W=4, ANIM_DIV=2, BLINK_DIV=3).
module tb_sprite_renderer;

   logic clk = 1'b0;
   logic rst_n;
   logic frame_start;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sprite_if #(.TILE_W(8), .COLOR_W(4)) ifa ();
   sprite_if #(.TILE_W(8), .COLOR_W(4)) ifb ();

   assign ifb.in_valid    = ifa.in_valid;
   assign ifb.sx          = ifa.sx;
   assign ifb.sy          = ifa.sy;
   assign ifb.sprite_code = ifa.sprite_code;
   assign ifb.pac_dir     = ifa.pac_dir;

   sprite_renderer #(.TILE_W(8), .COLOR_W(4), .ANIM_DIV(2), .BLINK_DIV(3), .BLINK_EN(1)) dut_a (
      .clk (clk), .rst_n (rst_n), .frame_start (frame_start), .bus (ifa.slave));

   sprite_renderer #(.TILE_W(8), .COLOR_W(4), .ANIM_DIV(2), .BLINK_DIV(3), .BLINK_EN(0)) dut_b (
      .clk (clk), .rst_n (rst_n), .frame_start (frame_start), .bus (ifb.slave));

   typedef struct {
      int         due;
      logic       ov;
      logic [11:0] rgb;
      logic [3:0] b2;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   // Reference animation state.
   bit m_mouth = 1'b0;
   bit m_pel   = 1'b1;
   int m_mcnt  = 0;
   int m_bcnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [11:0] golden(input int x, input int y, input int code,
                                          input int dir, input bit m, input bit p);
      int dx, dy, adx, ady;
      bit mouth;
      logic [3:0] r, g, b;
      r = 0; g = 0; b = 0;
      dx = 2 * x - 7;
      dy = 2 * y - 7;
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      if (code <= 7) begin
         r = 4'hF;
      end else if (code == 9) begin
         if ((x == 3 || x == 4) && (y == 3 || y == 4)) g = 4'hF;
      end else if (code == 10) begin
         if (x >= 3 && x <= 5 && y >= 3 && y <= 5 && p) b = 4'hF;
      end else if (code == 11) begin
         mouth = 1'b0;
         if (m) begin
            case (dir)
               0: mouth = (dx > 0) && (ady < dx);
               1: mouth = (dy < 0) && (adx < -dy);
               2: mouth = (dx < 0) && (ady < -dx);
               default: mouth = (dy > 0) && (adx < dy);
            endcase
         end
         if (dx * dx + dy * dy <= 64 && !mouth) begin
            r = 4'hF;
            g = 4'hF;
         end
      end
      return {r, g, b};
   endfunction

   // Compare DUT output with the scoreboard entry due this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         mon_e = q.pop_front();
         chk("out_valid", {31'b0, ifa.out_valid}, {31'b0, mon_e.ov});
         chk("rgb", {20'b0, ifa.R, ifa.G, ifa.B}, {20'b0, mon_e.rgb});
         chk("b_noblink", {28'b0, ifb.B}, {28'b0, mon_e.b2});
      end
   end

   task automatic px(input bit v, input int x, input int y, input int code,
                     input int dir, input bit fs);
      exp_t e;
      logic [11:0] nb;
      @(negedge clk);
      chk("mouth_open", {31'b0, ifa.mouth_open}, {31'b0, m_mouth});
      ifa.in_valid    = v;
      ifa.sx          = x[2:0];
      ifa.sy          = y[2:0];
      ifa.sprite_code = code[3:0];
      ifa.pac_dir     = dir[1:0];
      frame_start     = fs;
      nb    = golden(x, y, code, dir, m_mouth, 1'b1);
      e.due = cyc + 2;
      e.ov  = v;
      e.rgb = v ? golden(x, y, code, dir, m_mouth, m_pel) : 12'h000;
      e.b2  = v ? nb[3:0] : 4'h0;
      q.push_back(e);
      if (fs) begin
         if (m_mcnt == 1) begin m_mcnt = 0; m_mouth = ~m_mouth; end
         else m_mcnt++;
         if (m_bcnt == 2) begin m_bcnt = 0; m_pel = ~m_pel; end
         else m_bcnt++;
      end
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         px(0, 0, 0, 0, 0, 1);
         px(0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      ifa.in_valid = 1'b0;
      frame_start  = 1'b0;
      q.delete();
      #1;
      chk("rst_out_valid", {31'b0, ifa.out_valid}, 32'd0);
      chk("rst_rgb", {20'b0, ifa.R, ifa.G, ifa.B}, 32'd0);
      chk("rst_mouth", {31'b0, ifa.mouth_open}, 32'd0);
      chk("rst_out_valid_b", {31'b0, ifb.out_valid}, 32'd0);
      m_mouth = 1'b0; m_pel = 1'b1; m_mcnt = 0; m_bcnt = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      frame_start = 1'b0;
      ifa.in_valid = 1'b0;
      ifa.sx = '0;
      ifa.sy = '0;
      ifa.sprite_code = '0;
      ifa.pac_dir = '0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", {31'b0, ifa.out_valid}, 32'd0);
      chk("reset_rgb", {20'b0, ifa.R, ifa.G, ifa.B}, 32'd0);
      chk("reset_mouth", {31'b0, ifa.mouth_open}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Wall and blanking.
      px(1, 0, 0, 0, 0, 0);
      px(0, 0, 0, 0, 0, 0);
      px(1, 5, 2, 7, 0, 0);

      // Pellet sweep and black codes.
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 8; x++)
            px(1, x, y, 9, 0, 0);
      for (int x = 0; x < 8; x++) px(1, x, 3, 12, 0, 0);
      px(1, 4, 4, 8, 0, 0);
      px(1, 4, 4, 15, 0, 0);

      // Power pellet blink.
      px(1, 4, 4, 10, 0, 0);
      pulse(3);
      px(1, 4, 4, 10, 0, 0);
      px(1, 6, 4, 10, 0, 0);
      pulse(3);
      px(1, 4, 4, 10, 0, 0);
      px(1, 5, 5, 10, 0, 0);

      // Pac-Man in both mouth phases, all directions.
      for (int ph = 0; ph < 2; ph++) begin
         for (int d = 0; d < 4; d++)
            for (int y = 0; y < 8; y++)
               for (int x = 0; x < 8; x++)
                  px(1, x, y, 11, d, 0);
         pulse(2);
      end

      // frame_start coincident with a pixel on the toggling frame.
      for (int k = 0; k < 4 && m_mcnt != 1; k++) pulse(1);
      px(1, 7, 4, 11, 0, 1);
      px(1, 7, 4, 11, 0, 0);
      px(1, 0, 4, 11, 2, 0);

      // Random stream with an asynchronous reset mid-way.
      for (int i = 0; i < 100; i++) begin
         if (i == 50) do_reset();
         px(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 15),
            $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      end

      px(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("drain", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Parametrised, pipelined successor of the combinational tile sprite lookup.
- Maps a tile-local pixel coordinate and sprite code to an RGB pixel.
- Adds frame-synchronised animation: Pac-Man mouth open/close, and blinking power pellets.
- Sits between the tile-map fetch stage and the VGA output mux; a valid flag travels with each pixel.

Parameters:
- TILE_W, 8, tile edge in pixels; power of two, 8..32.
- COLOR_W, 4, bits per colour channel.
- ANIM_DIV, 8, frames per mouth toggle; ≥1.
- BLINK_DIV, 16, frames per power-pellet toggle; ≥1.
- BLINK_EN, 1, 0 keeps power pellets always visible.

Ports:
- clk, input, 1, pixel clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_start, input, 1, one-cycle pulse at the start of each frame.
- in_valid, input, 1, pixel request is valid (low during blanking).
- sx, input, $clog2(TILE_W), x within tile.
- sy, input, $clog2(TILE_W), y within tile.
- sprite_code, input, 4, tile sprite code.
- pac_dir, input, 2, Pac-Man facing: 0 right, 1 up, 2 left, 3 down.
- out_valid, output, 1, RGB valid.
- R, output, COLOR_W, red.
- G, output, COLOR_W, green.
- B, output, COLOR_W, blue.
- mouth_open, output, 1, current animation phase; for debug and verification.

Behaviour:
- Reset: out_valid=0, R=G=B=0, mouth_open=0, pellet_on=1, both frame counters=0.
- Latency: exactly 2 cycles from in_valid/sx/sy/code to out_valid/RGB.
  - Stage 1 registers the inputs plus dx=2*sx-(TILE_W-1) and dy=2*sy-(TILE_W-1), signed, width $clog2(TILE_W)+2.
  - Stage 2 registers the colour. Fully pipelined: one pixel per clock, no stalls.
- out_valid=0 → R=G=B=0.
- Sprite rules (FULL = all ones):
  - Codes 0–7 (walls): R=FULL, G=B=0.
  - Code 9 (pellet): G=FULL when sx,sy ∈ {TILE_W/2-1, TILE_W/2}; otherwise black.
  - Code 10 (power pellet): B=FULL when sx,sy ∈ [TILE_W/2-1, TILE_W/2+1] and pellet_on; otherwise black.
  - Code 11 (Pac-Man): R=G=FULL, B=0 when dx²+dy² ≤ TILE_W² and not in the mouth; otherwise black.
    - Mouth exists only when mouth_open=1.
    - Right: dx>0 and |dy|<dx.
    - Left: dx<0 and |dy|<-dx.
    - Up: dy<0 and |dx|<-dy.
    - Down: dy>0 and |dx|<dy.
  - All other codes (8, 12–15): black.
- Squared terms are computed unsigned at 2*($clog2(TILE_W)+2) bits; no truncation.
- Animation controller, advancing only on frame_start:
  - mouth_cnt increments; at ANIM_DIV-1 it wraps to 0 and toggles mouth_open.
  - blink_cnt does the same with BLINK_DIV and toggles pellet_on.
  - BLINK_EN=0 → pellet_on held at 1, blink counter unused.
- Animation state is sampled in stage 1. A pixel in flight when frame_start arrives uses the phase present when it entered stage 1.
- frame_start coincident with in_valid: both are processed; the pixel uses the pre-toggle phase.
- ANIM_DIV=1: mouth_open toggles every frame_start.
- rst_n asserted mid-frame: pipeline and counters clear immediately (async). First valid output comes 2 cycles after the first in_valid following release.

Decomposition:
- Package sprite_pkg holds:
  - sprite_code_t enum: WALL0..WALL7, PELLET=9, POWER=10, PACMAN=11.
  - dir_t enum: RIGHT, UP, LEFT, DOWN.
  - Colour-max function of COLOR_W.
- Sub-module sprite_anim_ctrl holds the frame counters and produces mouth_open and pellet_on.
- sprite_renderer instantiates it and implements the 2-stage datapath.

Test Plan (TILE_W=8, COLOR_W=4, ANIM_DIV=2, BLINK_DIV=3):
- Reset then code 0, sx=0, sy=0, in_valid=1 → 2 cycles later out_valid=1, R=F, G=0, B=0. Same request with in_valid=0 → out_valid=0, RGB=0.
- Code 9 sweep of all 64 pixels → G=F exactly at (3,3), (3,4), (4,3), (4,4); code 12 → always black.
- Code 10 at (4,4), frame_start pulsed 3 times → B=F before, B=0 after the third pulse, B=F after the sixth. With BLINK_EN=0 → always B=F.
- Code 11, pac_dir=0, mouth_open=0 → (7,4) yellow, (0,0) black. After 2 frame_start pulses (mouth_open=1) → (7,4) black, (0,4) yellow. pac_dir=2 → (0,4) black.
- frame_start coincident with a code-11 (7,4) request in the cycle the count reaches 1 → that pixel uses the old phase; the next pixel uses the new phase.
- Back-to-back stream of 100 random pixels with rst_n pulsed low mid-stream → outputs 0 immediately. After release, outputs match the golden model with 2-cycle latency and mouth_open=0.
